// File: rtl/frame_tx.sv
// frame_tx: UART-style serial transmitter for one board-state word.
// Frame = SYNC_BYTE followed by ceil(DATA_W/8) payload bytes. Each byte is
// start(0), 8 data bits LSB first, optional even parity, stop(1). Line idles high.
// Optional feature: define FRAME_TX_PARITY_EN to insert an even-parity bit
// after bit 7 of every byte (the far-end receiver must use the same setting).
module frame_tx #(
  parameter int unsigned CLKS_PER_BIT = 868,
  parameter int unsigned DATA_W       = 162,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic [DATA_W-1:0] data_in,
  input  logic              send,
  output logic              tx,
  output logic              busy,
  output logic              done
);

  localparam int unsigned NBYTES = (DATA_W + 7) / 8;
  localparam int unsigned PAD_W  = NBYTES * 8;
  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 2) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BYTE_W = $clog2(NBYTES + 1);

`ifdef FRAME_TX_PARITY_EN
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t              state_q, state_d;
  logic [BAUD_W-1:0]   baud_q, baud_d;
  logic [2:0]          bit_q, bit_d;
  logic [BYTE_W-1:0]   byte_cnt_q, byte_cnt_d;
  logic [PAD_W-1:0]    shreg_q, shreg_d;
  logic [7:0]          cur_q, cur_d;
  logic                tx_q, tx_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
`ifdef FRAME_TX_PARITY_EN
  logic                par_q, par_d;
`endif

  logic [PAD_W-1:0]    padded;
  logic                bit_end;

  // Zero-extend the input word to a whole number of bytes.
  always_comb begin
    padded               = '0;
    padded[DATA_W-1:0]   = data_in;
  end

  // Next-state logic: bit timing, byte sequencing and next line level.
  // tx_d is the level for the bit that begins on the coming edge, so the
  // line itself comes straight from a flop.
  always_comb begin
    state_d    = state_q;
    baud_d     = baud_q;
    bit_d      = bit_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    cur_d      = cur_q;
    tx_d       = tx_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
`ifdef FRAME_TX_PARITY_EN
    par_d      = par_q;
`endif
    bit_end    = (baud_q == BAUD_W'(CLKS_PER_BIT - 1));

    if (state_q != IDLE) begin
      baud_d = bit_end ? '0 : baud_q + 1'b1;
    end

    unique case (state_q)
      IDLE: begin
        if (send) begin
          state_d    = START;
          baud_d     = '0;
          bit_d      = '0;
          byte_cnt_d = '0;
          shreg_d    = padded;
          cur_d      = SYNC_BYTE;
`ifdef FRAME_TX_PARITY_EN
          par_d      = ^SYNC_BYTE;
`endif
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          bit_d   = '0;
          tx_d    = cur_q[0];
          cur_d   = {1'b0, cur_q[7:1]};
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bit_q == 3'd7) begin
`ifdef FRAME_TX_PARITY_EN
            state_d = PARITY;
            tx_d    = par_q;
`else
            state_d = STOP;
            tx_d    = 1'b1;
`endif
          end else begin
            bit_d = bit_q + 1'b1;
            tx_d  = cur_q[0];
            cur_d = {1'b0, cur_q[7:1]};
          end
        end
      end
`ifdef FRAME_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          tx_d    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          if (byte_cnt_q == BYTE_W'(NBYTES)) begin
            state_d = IDLE;
            tx_d    = 1'b1;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            state_d    = START;
            byte_cnt_d = byte_cnt_q + 1'b1;
            cur_d      = shreg_q[7:0];
`ifdef FRAME_TX_PARITY_EN
            par_d      = ^shreg_q[7:0];
`endif
            shreg_d    = {8'b0, shreg_q[PAD_W-1:8]};
            tx_d       = 1'b0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        tx_d    = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset aborts any frame at once.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q    <= IDLE;
      baud_q     <= '0;
      bit_q      <= '0;
      byte_cnt_q <= '0;
      shreg_q    <= '0;
      cur_q      <= '0;
      tx_q       <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
`ifdef FRAME_TX_PARITY_EN
      par_q      <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      baud_q     <= baud_d;
      bit_q      <= bit_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      cur_q      <= cur_d;
      tx_q       <= tx_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
`ifdef FRAME_TX_PARITY_EN
      par_q      <= par_d;
`endif
    end
  end

  assign tx   = tx_q;
  assign busy = busy_q;
  assign done = done_q;

endmodule

// File: tb/tb_frame_tx.sv
// Scoreboard bench for frame_tx at CLKS_PER_BIT = 4. Stimulus pushes expected
// bytes and done cycles; monitors decode the line and pop/compare.
module tb_frame_tx;

  localparam int CPB = 4;
  localparam int DW  = 162;
`ifdef FRAME_TX_PARITY_EN
  localparam int B = 11;
`else
  localparam int B = 10;
`endif
  localparam int F = 22 * B * CPB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic [DW-1:0] data_in = '0;
  logic          send = 1'b0;
  logic          tx, busy, done;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [7:0] exp_bytes[$];
  int         exp_done[$];

  frame_tx #(.CLKS_PER_BIT(CPB), .DATA_W(DW), .SYNC_BYTE(8'hA5)) dut (
    .clk_in(clk), .rst_in(rst_n), .data_in(data_in), .send(send),
    .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Line decoder: samples each bit mid-way and scores whole bytes.
  int         dpos = 0;
  bit         dact = 1'b0;
  logic [7:0] dbyte;
  always @(negedge clk) begin
    if (!rst_n) begin
      dact = 1'b0;
    end else if (!dact) begin
      if (tx == 1'b0) begin dact = 1'b1; dpos = 0; end
    end
    if (rst_n && dact) begin
      if (dpos % CPB == CPB / 2) begin
        automatic int j = dpos / CPB;
        if (j == 0) begin
          total++;
          if (tx !== 1'b0) begin bad++; $display("FAIL start_bit got=%b want=0 cyc=%0d", tx, cyc); end
        end else if (j <= 8) begin
          dbyte[j-1] = tx;
        end else if (j < B - 1) begin
          total++;
          if (tx !== ^dbyte) begin bad++; $display("FAIL parity_bit got=%b want=%b byte=%h", tx, ^dbyte, dbyte); end
        end else begin
          total++;
          if (tx !== 1'b1) begin bad++; $display("FAIL stop_bit got=%b want=1 cyc=%0d", tx, cyc); end
          total++;
          if (exp_bytes.size() == 0) begin
            bad++; $display("FAIL unexpected_byte got=%h want=none", dbyte);
          end else begin
            automatic logic [7:0] e = exp_bytes.pop_front();
            if (dbyte !== e) begin bad++; $display("FAIL byte got=%h want=%h cyc=%0d", dbyte, e, cyc); end
          end
          dact = 1'b0;
        end
      end
      dpos++;
    end
  end

  // done monitor: cycle of the pulse, and line/busy state in that cycle.
  always @(negedge clk) begin
    if (rst_n && done === 1'b1) begin
      total++;
      if (exp_done.size() == 0) begin
        bad++; $display("FAIL unexpected_done got=cyc%0d want=none", cyc);
      end else begin
        automatic int e = exp_done.pop_front();
        if (cyc != e) begin bad++; $display("FAIL done_cycle got=%0d want=%0d", cyc, e); end
      end
      total++;
      if (busy !== 1'b0 || tx !== 1'b1) begin
        bad++; $display("FAIL done_state got=busy%b_tx%b want=busy0_tx1", busy, tx);
      end
    end
  end

  // busy monitor: length of every completed busy interval.
  int blen = 0;
  always @(negedge clk) begin
    if (!rst_n) blen = 0;
    else if (busy === 1'b1) blen++;
    else if (blen > 0) begin
      total++;
      if (blen != F) begin bad++; $display("FAIL busy_len got=%0d want=%0d", blen, F); end
      blen = 0;
    end
  end

  task automatic push_frame(input logic [DW-1:0] d, input int e);
    logic [167:0] p;
    p = {6'b0, d};
    exp_bytes.push_back(8'hA5);
    for (int k = 1; k <= 21; k++) exp_bytes.push_back(p[8*k-8 +: 8]);
    exp_done.push_back(e + F);
  endtask

  task automatic start_frame(input logic [DW-1:0] d, output int e);
    @(negedge clk);
    data_in = d;
    send = 1'b1;
    @(posedge clk);
    #1;
    e = cyc;
    send = 1'b0;
    push_frame(d, e);
    total++;
    if (busy !== 1'b1 || tx !== 1'b0) begin
      bad++; $display("FAIL accept got=busy%b_tx%b want=busy1_tx0", busy, tx);
    end
  endtask

  task automatic wait_idle();
    int n;
    n = 0;
    while ((exp_bytes.size() != 0 || exp_done.size() != 0 || busy !== 1'b0) && n < 2 * F + 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 2 * F + 200) begin
      total++; bad++;
      $display("FAIL timeout got=bytes%0d_done%0d want=0_0", exp_bytes.size(), exp_done.size());
    end
    repeat (3) @(negedge clk);
  endtask

  logic [DW-1:0] d1, d2, d3, d4, d5, d6, d7, dp;
  int e, e2, lim;

  initial begin
    d1 = {2'b11, 152'b0, 8'hFF};
    d2 = {2'b01, 160'h0123456789ABCDEF_FEDCBA9876543210_DEADBEEF};
    d3 = {2'b10, 160'hA5A5_0000_FFFF_1234_5678_9ABC_DEF0_0F0F_F0F0_55AA};
    d4 = ~d3;
    d5 = {2'b11, 160'h8000_0000_0000_0000_0000_0000_0000_0000_0000_0001};
    d6 = {2'b01, {20{8'h81}}};
    d7 = {2'b10, {20{8'h3C}}};
    dp = {2'b00, 152'b0, 8'h07};

    // reset and quiet idle
    repeat (5) @(posedge clk);
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL reset_state got=%b%b%b want=100", tx, busy, done);
    end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (100) begin
      @(negedge clk);
      total++;
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
        bad++; $display("FAIL idle_state got=%b%b%b want=100", tx, busy, done);
      end
    end

    // single frame: A5 FF 00x19 03
    start_frame(d1, e);
    wait_idle();

    // input changed right after acceptance: latched value is sent
    start_frame(d2, e);
    @(negedge clk);
    data_in = '0;
    wait_idle();

    // sends during an active frame are ignored
    start_frame(d3, e);
    repeat (49) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    repeat (349) @(negedge clk);
    send = 1'b1;
    @(negedge clk);
    send = 1'b0;
    wait_idle();

    // reset mid-frame aborts asynchronously
    start_frame(d4, e);
    repeat (299) @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    total++;
    if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) begin
      bad++; $display("FAIL async_reset got=%b%b%b want=100", tx, busy, done);
    end
    exp_bytes.delete();
    exp_done.delete();
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    start_frame(d5, e);
    wait_idle();

    // back-to-back with send held: next accept on the done cycle edge
    start_frame(d6, e);
    send = 1'b1;
    data_in = d7;
    e2 = e + F + 1;
    push_frame(d7, e2);
    lim = 0;
    while (cyc < e2 && lim < 2 * F) begin
      @(posedge clk);
      #1;
      lim++;
    end
    send = 1'b0;
    total++;
    if (cyc != e2 || busy !== 1'b1 || tx !== 1'b0) begin
      bad++; $display("FAIL b2b_accept got=cyc%0d_busy%b_tx%b want=cyc%0d_busy1_tx0", cyc, busy, tx, e2);
    end
    wait_idle();

    // low byte 07 (parity 1 when enabled)
    start_frame(dp, e);
    wait_idle();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
